regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count (power of two, at least 2); AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2: number of read ports.
REQ-004 SHALL have parameter CNTW, default 2: width of each pending-write counter.
REQ-005 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding.
REQ-006 SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*WIDTH  read data, packed the same way.
- rd_busy  out  NRD  per-port "pending write outstanding" flag.
- wr_en  in  1  write-back strobe.
- wr_addr  in  AW  write-back address.
- wr_data  in  WIDTH  write-back data.
- wr_pc  in  32  PC of the writing instruction; trace only.
- rsv_en  in  1  reserve a pending write (issue).
- rsv_addr  in  AW  register being reserved.
- flush  in  1  synchronous clear of all reservations.
- err_ovf  out  1  sticky: reservation hit a saturated counter.
- err_unf  out  1  sticky: write-back arrived with a zero counter.

Function
REQ-007 Register 0 SHALL read as 0 at all times; writes to it and reservations of it SHALL be ignored.
REQ-008 Reads SHALL be combinational: rd_data for port k is the content of rf[rd_addr k].
REQ-009 With BYPASS=1, when wr_en is high and wr_addr equals rd_addr k (nonzero), rd_data for port k SHALL be wr_data in the same cycle.
REQ-010 When wr_en is high and wr_addr is nonzero, rf[wr_addr] SHALL take wr_data at the clock edge, regardless of counter state or flush.
REQ-011 On each such write, simulation SHALL print "@<pc hex>: $<addr dec> <= <data hex>"; writes to register 0 SHALL NOT print.
REQ-012 Each register r>0 SHALL have a CNTW-bit counter cnt[r] holding the number of outstanding reservations.
REQ-013 Counter next state per edge, flush low:
- rsv only: +1.
- write-back only: -1.
- both to the same r: unchanged.
REQ-014 A reservation when cnt[r] = 2^CNTW-1 SHALL leave the counter unchanged and set err_ovf (unless a same-r write-back also occurs: then the counter is unchanged and no error is raised).
REQ-015 A write-back when cnt[r] = 0 and no same-r reservation SHALL leave the counter at 0 and set err_unf; the data write still occurs.
REQ-016 flush high SHALL zero all counters at the edge, overriding rsv_en and write-back decrements; err flags SHALL NOT be set in a flush cycle.
REQ-017 rd_busy for port k SHALL be high iff, for the nonzero address a = rd_addr k, either:
- cnt[a] > 1, or
- cnt[a] = 1 and not (wr_en and wr_addr = a).
A same-cycle reservation SHALL NOT affect rd_busy.
REQ-018 err_ovf and err_unf SHALL stay set until reset.

Reset
REQ-019 While reset is low, all rf entries, all counters, err_ovf and err_unf SHALL be 0 immediately (asynchronous); rd_busy SHALL then be all 0.
REQ-020 Reset assertion during any operation SHALL discard all in-flight updates; release SHALL take effect synchronously with no spurious write.

Structure
REQ-021 Parameter defaults and the AW derivation SHALL live in shared package grf_pkg.
REQ-022 The per-register counter with saturation and error detection SHALL be a sub-module sb_counter, instantiated NREG-1 times.

Verification
REQ-023 Reset, then write r5=0x12345678 at pc 0x3000 -> the next-cycle read of r5 returns 0x12345678; the trace line "@00003000: $ 5 <= 12345678" is printed.
REQ-024 Write r0=0xFFFFFFFF -> r0 reads 0; no trace line; no flag changes.
REQ-025 Reserve r7 twice, then write r7 once -> rd_busy stays 1; on the second write, rd_busy goes 0 in that same cycle and rd_data shows the bypassed value.
REQ-026 With CNTW=2, reserve r3 four times -> cnt stays 3 and err_ovf=1; write r3 with cnt 0 -> err_unf=1 and the data is written.
REQ-027 Reservation and write-back of r9 in the same cycle with cnt 1 -> cnt stays 1; flush with a simultaneous rsv r9 -> cnt 0 and rd_busy 0.
REQ-028 Drive reset low mid-sequence with cnt[4]=2 -> all reads 0 and rd_busy 0 before the next edge.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared defaults and address-width derivation for the scoreboarded register file.
package grf_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int NREG_DEF   = 32;
  localparam int NRD_DEF    = 2;
  localparam int CNTW_DEF   = 2;
  localparam int BYPASS_DEF = 1;

  function automatic int aw_of(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one register: saturates at both ends and flags the
// offending event as a one-cycle pulse.
module sb_counter #(
  parameter int CNTW = grf_pkg::CNTW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic rsv,
  input  logic wb,
  input  logic flush,
  output logic busy,
  output logic ovf_evt,
  output logic unf_evt
);

  localparam logic [CNTW-1:0] CMAX = '1;
  localparam logic [CNTW-1:0] CONE = CNTW'(1);

  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nxt;

  // A same-register reserve and write-back cancel; flush wins over both.
  always_comb begin
    cnt_nxt = cnt;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (flush) begin
      cnt_nxt = '0;
    end else if (rsv && !wb) begin
      if (cnt == CMAX) ovf_evt = 1'b1;
      else             cnt_nxt = cnt + CONE;
    end else if (wb && !rsv) begin
      if (cnt == '0) unf_evt = 1'b1;
      else           cnt_nxt = cnt - CONE;
    end
  end

  // The last outstanding write retiring this cycle is already visible via bypass.
  assign busy = (cnt > CONE) || ((cnt == CONE) && !wb);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register pending-write tracking, optional
// write-to-read forwarding and sticky over/underflow error flags.
module regfile_scoreboard
  import grf_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int NREG   = NREG_DEF,
  parameter  int NRD    = NRD_DEF,
  parameter  int CNTW   = CNTW_DEF,
  parameter  int BYPASS = BYPASS_DEF,
  localparam int AW     = aw_of(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [31:0]          wr_pc,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 flush,
  output logic                 err_ovf,
  output logic                 err_unf
);

  logic [WIDTH-1:0] rf [NREG];
  logic [NREG-1:0]  busy_r;
  logic [NREG-1:0]  ovf_evt;
  logic [NREG-1:0]  unf_evt;
  logic             wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  // Register 0 has no counter, so it is never busy and never raises errors.
  assign busy_r[0]  = 1'b0;
  assign ovf_evt[0] = 1'b0;
  assign unf_evt[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.CNTW(CNTW)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .rsv    (rsv_en && (rsv_addr == AW'(r))),
      .wb     (wr_en && (wr_addr == AW'(r))),
      .flush  (flush),
      .busy   (busy_r[r]),
      .ovf_evt(ovf_evt[r]),
      .unf_evt(unf_evt[r])
    );
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = rd_addr[k*AW +: AW];
    assign hit = (BYPASS != 0) && wr_en && (wr_addr == ra);
    assign rd_data[k*WIDTH +: WIDTH] = (ra == '0) ? '0 : (hit ? wr_data : rf[ra]);
    assign rd_busy[k] = busy_r[ra];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (wr_live) begin
        rf[wr_addr] <= wr_data;
        $display("@%h: $%d <= %h", wr_pc, wr_addr, wr_data);
      end
      err_ovf <= err_ovf | (|ovf_evt);
      err_unf <= err_unf | (|unf_evt);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expectations queued when stimulus is
// driven, popped and asserted when the outputs are sampled.
module tb_regfile_scoreboard;

  localparam int WIDTH = 32;
  localparam int NREG  = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic [31:0]          wr_pc;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic                 flush;
  logic                 err_ovf;
  logic                 err_unf;

  int n_assert = 0;
  int n_fail   = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  regfile_scoreboard #(
    .WIDTH(WIDTH), .NREG(NREG), .NRD(NRD), .CNTW(2), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_pc(wr_pc), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL empty_queue: observed %h required a queued expectation", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  function automatic logic [31:0] rd0();
    return rd_data[31:0];
  endfunction

  function automatic logic [31:0] rd1();
    return rd_data[63:32];
  endfunction

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_pc = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    rd_addr = {5'd7, 5'd5};
    #3;
    expect_v("rst_rd0", 32'h0);  chk(rd0());
    expect_v("rst_busy", 32'h0); chk(32'(rd_busy));
    expect_v("rst_ovf", 32'h0);  chk(32'(err_ovf));
    expect_v("rst_unf", 32'h0);  chk(32'(err_unf));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // r5: reserve then write at pc 0x3000
    rsv_en = 1'b1; rsv_addr = 5'd5; tick(); rsv_en = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678; wr_pc = 32'h3000;
    expect_v("byp_r5", 32'h12345678); #1 chk(rd0());
    tick(); wr_en = 1'b0;
    expect_v("rd_r5", 32'h12345678); expect_v("busy_r5", 32'h0);
    #1 chk(rd0()); chk(32'(rd_busy[0]));

    // r0 is hardwired zero
    rd_addr = {5'd0, 5'd5};
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_pc = 32'h3004;
    expect_v("byp_r0", 32'h0); #1 chk(rd1());
    tick(); wr_en = 1'b0;
    expect_v("rd_r0", 32'h0); expect_v("r0_ovf", 32'h0); expect_v("r0_unf", 32'h0);
    #1 chk(rd1()); chk(32'(err_ovf)); chk(32'(err_unf));

    // r7: two reservations, two write-backs
    rd_addr = {5'd7, 5'd5};
    rsv_en = 1'b1; rsv_addr = 5'd7; tick(); tick(); rsv_en = 1'b0;
    expect_v("r7_busy_cnt2", 32'h1); #1 chk(32'(rd_busy[1]));
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAAAA0001; wr_pc = 32'h3008;
    expect_v("r7_busy_wb1", 32'h1); expect_v("r7_byp1", 32'hAAAA0001);
    #1 chk(32'(rd_busy[1])); chk(rd1());
    tick(); wr_en = 1'b0;
    expect_v("r7_busy_cnt1", 32'h1); #1 chk(32'(rd_busy[1]));
    wr_en = 1'b1; wr_data = 32'hBBBB0002; wr_pc = 32'h300C;
    expect_v("r7_busy_wb2", 32'h0); expect_v("r7_byp2", 32'hBBBB0002);
    #1 chk(32'(rd_busy[1])); chk(rd1());
    tick(); wr_en = 1'b0;
    expect_v("r7_busy_done", 32'h0); expect_v("r7_rd", 32'hBBBB0002);
    expect_v("r7_unf", 32'h0);
    #1 chk(32'(rd_busy[1])); chk(rd1()); chk(32'(err_unf));

    // r3: saturate at 3, then drain and underflow
    rd_addr = {5'd7, 5'd3};
    rsv_en = 1'b1; rsv_addr = 5'd3; repeat (3) tick();
    expect_v("r3_ovf_pre", 32'h0); expect_v("r3_busy", 32'h1);
    #1 chk(32'(err_ovf)); chk(32'(rd_busy[0]));
    tick(); rsv_en = 1'b0;
    expect_v("r3_ovf", 32'h1); #1 chk(32'(err_ovf));
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h31; wr_pc = 32'h3010; tick();
    wr_data = 32'h32; wr_pc = 32'h3014; tick(); wr_en = 1'b0;
    expect_v("r3_busy_cnt1", 32'h1); #1 chk(32'(rd_busy[0]));
    wr_en = 1'b1; wr_data = 32'h33; wr_pc = 32'h3018;
    expect_v("r3_busy_last", 32'h0); #1 chk(32'(rd_busy[0]));
    tick(); wr_en = 1'b0;
    expect_v("r3_unf_pre", 32'h0); expect_v("r3_rd33", 32'h33);
    #1 chk(32'(err_unf)); chk(rd0());
    wr_en = 1'b1; wr_data = 32'h00C0FFEE; wr_pc = 32'h301C; tick(); wr_en = 1'b0;
    expect_v("r3_unf", 32'h1); expect_v("r3_unf_data", 32'h00C0FFEE);
    expect_v("r3_ovf_sticky", 32'h1);
    #1 chk(32'(err_unf)); chk(rd0()); chk(32'(err_ovf));

    // r9: simultaneous reserve+write, then flush beats reserve
    rd_addr = {5'd7, 5'd9};
    rsv_en = 1'b1; rsv_addr = 5'd9; tick(); rsv_en = 1'b0;
    expect_v("r9_busy", 32'h1); #1 chk(32'(rd_busy[0]));
    rsv_en = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; wr_pc = 32'h3020;
    expect_v("r9_busy_same", 32'h0); #1 chk(32'(rd_busy[0]));
    tick(); rsv_en = 1'b0; wr_en = 1'b0;
    expect_v("r9_cnt_kept", 32'h1); expect_v("r9_rd", 32'h99);
    #1 chk(32'(rd_busy[0])); chk(rd0());
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd9; tick(); flush = 1'b0; rsv_en = 1'b0;
    expect_v("r9_flushed", 32'h0); #1 chk(32'(rd_busy[0]));

    // r4: asynchronous reset with two writes outstanding
    rd_addr = {5'd4, 5'd5};
    rsv_en = 1'b1; rsv_addr = 5'd4; repeat (3) tick(); rsv_en = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; wr_pc = 32'h3024; tick(); wr_en = 1'b0;
    expect_v("r4_busy", 32'h1); expect_v("r4_rd", 32'h44); expect_v("r5_still", 32'h12345678);
    #1 chk(32'(rd_busy[1])); chk(rd1()); chk(rd0());
    #1 reset = 1'b0;
    expect_v("arst_rd0", 32'h0); expect_v("arst_rd1", 32'h0); expect_v("arst_busy", 32'h0);
    expect_v("arst_ovf", 32'h0); expect_v("arst_unf", 32'h0);
    #1 chk(rd0()); chk(rd1()); chk(32'(rd_busy)); chk(32'(err_ovf)); chk(32'(err_unf));
    tick(); reset = 1'b1; tick();
    expect_v("post_rd1", 32'h0); expect_v("post_busy", 32'h0);
    #1 chk(rd1()); chk(32'(rd_busy));

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL leftover_queue: observed %0d unchecked entries, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
